// File: rtl/mux_rr_pkg.sv
// Shared types and constants for the round-robin 4:1 mux select controller.
package mux_rr_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Channel index after c, wrapping 3 -> 0.
  function automatic ch_idx_t ch_inc(input ch_idx_t c);
    return c + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set bit of req_i scanning from ptr_i upward, mod 4.
module rr_pick4
  import mux_rr_pkg::*;
(
  input  logic [CH_NUM-1:0] req_i,
  input  ch_idx_t           ptr_i,
  output ch_idx_t           pick_o,
  output logic              any_o
);

  always_comb begin
    ch_idx_t idx;
    idx    = ptr_i;
    pick_o = ptr_i;
    any_o  = |req_i;
    // Walk the offsets from farthest to nearest so the nearest request wins.
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      idx = ptr_i + ch_idx_t'(i);
      if (req_i[idx]) pick_o = idx;
    end
  end

endmodule

// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin select controller feeding a 4:1 mux, with a one-deep valid/ready output register.
// Optional per-channel grant counters are enabled with `define MUX_RR_STATS_EN.
module mux_rr_sel_ctrl
  import mux_rr_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] in_valid,
  output logic [CH_NUM-1:0] in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_ch
`ifdef MUX_RR_STATS_EN
  ,
  output logic [63:0]       grant_cnt
`endif
);

  state_t            state_q, state_d;
  ch_idx_t           ptr_q, ptr_d;
  ch_idx_t           cur_q, cur_d;
  logic [3:0]        burst_q, burst_d;
  logic [DATA_W-1:0] data_q, data_d;
  ch_idx_t           ch_q, ch_d;

  ch_idx_t           rr_pick;
  logic              any_req;
  ch_idx_t           pick;
  logic              load;
  logic              burst_cont;
  logic              accept;
  logic [4:0]        burst_nxt;
  logic [DATA_W-1:0] lane;

  rr_pick4 u_pick (
    .req_i  (in_valid),
    .ptr_i  (ptr_q),
    .pick_o (rr_pick),
    .any_o  (any_req)
  );

  // The output register can be refilled in the same cycle it drains.
  assign load       = (state_q == IDLE) | out_ready;
  assign burst_nxt  = {1'b0, burst_q} + 5'd1;
  assign burst_cont = (state_q == HOLD) && (burst_nxt < 5'(MAX_BURST)) && in_valid[cur_q];
  assign pick       = burst_cont ? cur_q : rr_pick;
  assign accept     = load & any_req & ~rst;
  assign in_ready   = accept ? (CH_NUM'(1) << pick) : '0;

  always_comb begin
    case (pick)
      2'd1:    lane = in_data1;
      2'd2:    lane = in_data2;
      2'd3:    lane = in_data3;
      default: lane = in_data0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    burst_d = burst_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (load) begin
      if (any_req) begin
        state_d = HOLD;
        data_d  = lane;
        ch_d    = pick;
        ptr_d   = ch_inc(pick);
        if (burst_cont) begin
          burst_d = burst_q + 4'd1;
        end else begin
          cur_d   = pick;
          burst_d = '0;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      burst_q <= '0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign sel       = ch_q;

`ifdef MUX_RR_STATS_EN
  logic [CH_NUM-1:0][15:0] gcnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (accept && (pick == ch_idx_t'(i))) gcnt_q[i] <= sat_inc16(gcnt_q[i]);
      end
    end
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_sel_ctrl.sv
// Bench for mux_rr_sel_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_mux_rr_sel_ctrl;

  localparam int MB0 = 1;
  localparam int MB1 = 3;

  logic       clk;
  logic       rst;
  logic [3:0] in_valid;
  logic       out_ready;
  logic [7:0] din [4];

  logic [3:0] a_rdy, b_rdy;
  logic [1:0] a_sel, b_sel, a_ch, b_ch;
  logic       a_ov, b_ov;
  logic [7:0] a_dat, b_dat;
`ifdef MUX_RR_STATS_EN
  logic [63:0] a_gc, b_gc;
`endif

  logic [3:0] rdy_w [2];
  logic [1:0] sel_w [2];
  logic [1:0] ch_w  [2];
  logic       ov_w  [2];
  logic [7:0] dat_w [2];

  assign rdy_w[0] = a_rdy;  assign rdy_w[1] = b_rdy;
  assign sel_w[0] = a_sel;  assign sel_w[1] = b_sel;
  assign ch_w[0]  = a_ch;   assign ch_w[1]  = b_ch;
  assign ov_w[0]  = a_ov;   assign ov_w[1]  = b_ov;
  assign dat_w[0] = a_dat;  assign dat_w[1] = b_dat;

  int vectors;
  int miscompares;

  mux_rr_sel_ctrl #(.DATA_W(8), .MAX_BURST(MB0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .sel(a_sel), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_dat), .out_ch(a_ch)
`ifdef MUX_RR_STATS_EN
    , .grant_cnt(a_gc)
`endif
  );

  mux_rr_sel_ctrl #(.DATA_W(8), .MAX_BURST(MB1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
    .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
    .sel(b_sel), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_dat), .out_ch(b_ch)
`ifdef MUX_RR_STATS_EN
    , .grant_cnt(b_gc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  bit         m_vld  [2];
  logic [7:0] m_data [2];
  int         m_ch   [2];
  int         m_ptr  [2];
  int         m_cur  [2];
  int         m_bcnt [2];

  task automatic drive(input logic r, input logic [3:0] v, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  function automatic int model_pick(input int k, input logic [3:0] v, input logic ordy,
                                    output bit cont);
    int res;
    int mb;
    res  = -1;
    cont = 1'b0;
    mb   = (k == 0) ? MB0 : MB1;
    if ((!m_vld[k] || ordy) && (v != 4'b0000)) begin
      if (m_vld[k] && (m_bcnt[k] < mb - 1) && v[m_cur[k]]) begin
        cont = 1'b1;
        res  = m_cur[k];
      end else begin
        for (int i = 3; i >= 0; i--) begin
          if (v[(m_ptr[k] + i) % 4]) res = (m_ptr[k] + i) % 4;
        end
      end
    end
    return res;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0; m_data[k] = 8'h00; m_ch[k] = 0;
      m_ptr[k] = 0;    m_cur[k]  = 0;     m_bcnt[k] = 0;
    end
  endfunction

  task automatic test_reset();
    din[0] = 8'h10; din[1] = 8'h11; din[2] = 8'h12; din[3] = 8'h13;
    drive(1'b1, 4'b1111, 1'b1);
    vectors++; if (a_rdy !== 4'b0000) begin miscompares++; $display("FAIL rst_rdy_a0: got %b want 0000", a_rdy); end
    vectors++; if (b_rdy !== 4'b0000) begin miscompares++; $display("FAIL rst_rdy_b0: got %b want 0000", b_rdy); end
    drive(1'b1, 4'b1111, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors++; if (rdy_w[k] !== 4'b0000) begin miscompares++; $display("FAIL rst_rdy%0d: got %b want 0000", k, rdy_w[k]); end
      vectors++; if (ov_w[k] !== 1'b0) begin miscompares++; $display("FAIL rst_ovalid%0d: got %b want 0", k, ov_w[k]); end
      vectors++; if (dat_w[k] !== 8'h00) begin miscompares++; $display("FAIL rst_odata%0d: got %h want 00", k, dat_w[k]); end
      vectors++; if (ch_w[k] !== 2'd0) begin miscompares++; $display("FAIL rst_och%0d: got %0d want 0", k, ch_w[k]); end
      vectors++; if (sel_w[k] !== 2'd0) begin miscompares++; $display("FAIL rst_sel%0d: got %0d want 0", k, sel_w[k]); end
    end
    drive(1'b0, 4'b1111, 1'b1);
    vectors++; if (a_rdy !== 4'b0001) begin miscompares++; $display("FAIL rst_first_grant: got %b want 0001", a_rdy); end
    drive(1'b0, 4'b1111, 1'b1);
    vectors++; if ({a_ov, a_ch, a_dat} !== {1'b1, 2'd0, 8'h10}) begin
      miscompares++; $display("FAIL rst_first_beat: got v=%b ch=%0d d=%h want v=1 ch=0 d=10", a_ov, a_ch, a_dat);
    end
  endtask

  task automatic test_round_robin();
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b0, 4'b1111, 1'b1);
    vectors++; if (a_rdy !== 4'b0001) begin miscompares++; $display("FAIL rr_rdy_start: got %b want 0001", a_rdy); end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 4'b1111, 1'b1);
      vectors++;
      if ({a_ov, a_ch, a_sel, a_dat} !== {1'b1, 2'((k - 1) % 4), 2'((k - 1) % 4), 8'(8'h10 + (k - 1) % 4)}) begin
        miscompares++;
        $display("FAIL rr_beat%0d: got v=%b ch=%0d sel=%0d d=%h want v=1 ch=%0d", k, a_ov, a_ch, a_sel, a_dat, (k - 1) % 4);
      end
      vectors++; if (a_rdy !== 4'(1 << (k % 4))) begin miscompares++; $display("FAIL rr_rdy%0d: got %b want %b", k, a_rdy, 4'(1 << (k % 4))); end
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'b0000, 1'b1);
    din[2] = 8'h01; din[3] = 8'h5A;
    drive(1'b0, 4'b0100, 1'b1);
    vectors++; if (a_rdy !== 4'b0100) begin miscompares++; $display("FAIL bp_rdy_first: got %b want 0100", a_rdy); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, (k == 0) ? 4'b0100 : 4'b1111, 1'b0);
      vectors++; if ({a_ov, a_dat, a_sel, a_rdy} !== {1'b1, 8'h01, 2'b10, 4'b0000}) begin
        miscompares++; $display("FAIL bp_stall%0d: got v=%b d=%h sel=%b rdy=%b want v=1 d=01 sel=10 rdy=0000", k, a_ov, a_dat, a_sel, a_rdy);
      end
    end
    drive(1'b0, 4'b1000, 1'b1);
    vectors++; if (a_rdy !== 4'b1000) begin miscompares++; $display("FAIL bp_release_rdy: got %b want 1000", a_rdy); end
    drive(1'b0, 4'b0000, 1'b1);
    vectors++; if ({a_ov, a_ch, a_dat, a_rdy} !== {1'b1, 2'd3, 8'h5A, 4'b0000}) begin
      miscompares++; $display("FAIL bp_next_beat: got v=%b ch=%0d d=%h rdy=%b want v=1 ch=3 d=5a rdy=0000", a_ov, a_ch, a_dat, a_rdy);
    end
    drive(1'b0, 4'b0000, 1'b1);
    vectors++; if ({a_ov, a_ch, a_dat} !== {1'b0, 2'd3, 8'h5A}) begin
      miscompares++; $display("FAIL bp_drain: got v=%b ch=%0d d=%h want v=0 ch=3 d=5a", a_ov, a_ch, a_dat);
    end
  endtask

  task automatic test_burst();
    logic [1:0] seq [7];
    seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b0, 4'b0011, 1'b1);
    vectors++; if (b_rdy !== 4'b0001) begin miscompares++; $display("FAIL burst_rdy_start: got %b want 0001", b_rdy); end
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 4'b0011, 1'b1);
      vectors++; if ({b_ov, b_ch} !== {1'b1, seq[k]}) begin
        miscompares++; $display("FAIL burst_beat%0d: got v=%b ch=%0d want v=1 ch=%0d", k, b_ov, b_ch, seq[k]);
      end
    end
    drive(1'b0, 4'b0010, 1'b1);
    vectors++; if (b_rdy !== 4'b0010) begin miscompares++; $display("FAIL burst_drop_rdy: got %b want 0010", b_rdy); end
    drive(1'b0, 4'b0000, 1'b1);
    vectors++; if (b_ch !== 2'd1) begin miscompares++; $display("FAIL burst_drop_ch: got %0d want 1", b_ch); end
  endtask

  task automatic test_wrap_idle();
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b0, 4'b1000, 1'b1);
    vectors++; if (a_rdy !== 4'b1000) begin miscompares++; $display("FAIL wrap_rdy3: got %b want 1000", a_rdy); end
    drive(1'b0, 4'b1001, 1'b1);
    vectors++; if (a_ch !== 2'd3) begin miscompares++; $display("FAIL wrap_ch3: got %0d want 3", a_ch); end
    vectors++; if (a_rdy !== 4'b0001) begin miscompares++; $display("FAIL wrap_ch0_wins: got %b want 0001", a_rdy); end
    drive(1'b0, 4'b0000, 1'b1);
    vectors++; if ({a_ov, a_ch, a_rdy} !== {1'b1, 2'd0, 4'b0000}) begin
      miscompares++; $display("FAIL wrap_beat0: got v=%b ch=%0d rdy=%b want v=1 ch=0 rdy=0000", a_ov, a_ch, a_rdy);
    end
    drive(1'b0, 4'b0000, 1'b1);
    vectors++; if ({a_ov, a_ch} !== {1'b0, 2'd0}) begin
      miscompares++; $display("FAIL wrap_idle: got v=%b ch=%0d want v=0 ch=0", a_ov, a_ch);
    end
  endtask

  task automatic test_random();
    int  p [2];
    bit  c [2];
    logic [3:0] exp_rdy;
    drive(1'b1, 4'b0000, 1'b1);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        p[k]    = model_pick(k, in_valid, out_ready, c[k]);
        exp_rdy = (rst || p[k] < 0) ? 4'b0000 : 4'(1 << p[k]);
        vectors++; if (rdy_w[k] !== exp_rdy) begin miscompares++; $display("FAIL rand_rdy%0d cyc %0d: got %b want %b", k, n, rdy_w[k], exp_rdy); end
        vectors++; if (ov_w[k] !== m_vld[k]) begin miscompares++; $display("FAIL rand_ovalid%0d cyc %0d: got %b want %b", k, n, ov_w[k], m_vld[k]); end
        vectors++; if (dat_w[k] !== m_data[k]) begin miscompares++; $display("FAIL rand_odata%0d cyc %0d: got %h want %h", k, n, dat_w[k], m_data[k]); end
        vectors++; if ({ch_w[k], sel_w[k]} !== {2'(m_ch[k]), 2'(m_ch[k])}) begin
          miscompares++; $display("FAIL rand_och%0d cyc %0d: got ch=%0d sel=%0d want %0d", k, n, ch_w[k], sel_w[k], m_ch[k]);
        end
      end
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (p[k] >= 0) begin
            m_vld[k]  = 1'b1;
            m_data[k] = din[p[k]];
            m_ch[k]   = p[k];
            if (c[k]) m_bcnt[k]++;
            else begin m_cur[k] = p[k]; m_bcnt[k] = 0; end
            m_ptr[k] = (p[k] + 1) % 4;
          end else if (!m_vld[k] || out_ready) begin
            m_vld[k] = 1'b0;
          end
        end
      end
    end
  endtask

`ifdef MUX_RR_STATS_EN
  task automatic test_stats();
    drive(1'b1, 4'b0010, 1'b1);
    drive(1'b1, 4'b0010, 1'b1);
    vectors++; if (a_gc !== 64'd0) begin miscompares++; $display("FAIL stats_rst: got %h want 0", a_gc); end
    for (int j = 1; j <= 70002; j++) begin
      drive(1'b0, 4'b0010, 1'b1);
      if (j == 101) begin
        vectors++; if (a_gc !== (64'd100 << 16)) begin miscompares++; $display("FAIL stats_100: got %h want %h", a_gc, 64'd100 << 16); end
      end
    end
    vectors++; if (a_gc !== (64'hFFFF << 16)) begin miscompares++; $display("FAIL stats_sat_a: got %h want %h", a_gc, 64'hFFFF << 16); end
    vectors++; if (b_gc !== (64'hFFFF << 16)) begin miscompares++; $display("FAIL stats_sat_b: got %h want %h", b_gc, 64'hFFFF << 16); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 4'b0000;
    out_ready   = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_burst();
    test_wrap_idle();
    test_random();
`ifdef MUX_RR_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
